prim_assembler: RTL and testbench

Parametrised primitive assembler between the per-attribute vertex FIFOs and the rasterizer. It pops one entry from every attribute channel FIFO in lock-step, gathers VERTS vertices into a primitive, and presents completed primitives through a two-slot ping-pong buffer. The buffer lets the next primitive be gathered while the rasterizer is still consuming the current one. A valid/dequeue handshake drives the rasterizer, and an accepted-primitive counter is provided for debug.

---
 rtl/prim_assembler.sv | 159 +++++++++++++++
 tb/tb_prim_assembler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_assembler.sv
// ---------------------------------------------------------------------------
// prim_assembler
//
// Purpose:
//   Sits between the per-attribute vertex FIFOs and the rasterizer. It pops
//   one word from every attribute channel in lock-step and gathers VERTS
//   vertices into a primitive. Finished primitives are presented through a
//   two-slot ping-pong buffer, so the next primitive can be gathered while
//   the consumer still holds the current one.
//
// Parameters:
//   DATA_W  width of one attribute word
//   NUM_CH  number of attribute channels (ch0 = position, ch1 = color, ...)
//   VERTS   vertices per primitive (>= 2)
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   fifo_empty    per-channel FIFO empty flags
//   fifo_dout     FIFO read data, channel c at [c*DATA_W +: DATA_W]
//                 (standard-mode FIFO: data valid the cycle after rd_en)
//   fifo_rd_en    per-channel pop, all bits identical
//   prim_data     presented primitive, vertex v / channel c at
//                 [(v*NUM_CH+c)*DATA_W +: DATA_W]
//   prim_valid    prim_data holds a complete primitive
//   prim_dequeue  consumer pulse releasing the presented primitive
//   prim_count    primitives accepted by the consumer (wraps at 2^16)
// ---------------------------------------------------------------------------
module prim_assembler #(
    parameter int DATA_W = 96,
    parameter int NUM_CH = 2,
    parameter int VERTS  = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CH-1:0]               fifo_empty,
    input  logic [NUM_CH*DATA_W-1:0]        fifo_dout,
    output logic [NUM_CH-1:0]               fifo_rd_en,
    output logic [VERTS*NUM_CH*DATA_W-1:0]  prim_data,
    output logic                            prim_valid,
    input  logic                            prim_dequeue,
    output logic [15:0]                     prim_count
);

    localparam int VERT_W = NUM_CH * DATA_W;
    localparam int CNT_W  = $clog2(VERTS + 1);

    // Slot storage: one word of all channels per vertex, two slots.
    logic [VERT_W-1:0] r_vert [2][VERTS];

    logic [1:0]        r_full;
    logic              r_gather_sel;
    logic              r_out_sel;
    logic [CNT_W-1:0]  r_issued;
    logic [CNT_W-1:0]  r_captured;
    logic              r_cap_pending;
    logic [15:0]       r_prim_count;

    logic              w_all_ready;
    logic              w_pop;
    logic              w_last_cap;
    logic              w_deq_accept;
    logic [1:0]        w_full_next;

    // ------------------------------------------------------------------
    // Pop issue: purely combinational from registered state and the empty
    // flags, so the FIFO sees the request in the same cycle. Gated by rst
    // so no FIFO entry is lost while the assembler is held in reset.
    // ------------------------------------------------------------------
    assign w_all_ready = ~|fifo_empty;
    assign w_pop       = !rst && w_all_ready &&
                         (r_issued < CNT_W'(VERTS)) &&
                         !r_full[r_gather_sel];
    assign fifo_rd_en  = {NUM_CH{w_pop}};

    // The VERTS-th capture closes the primitive in the slot being filled.
    assign w_last_cap   = r_cap_pending && (r_captured == CNT_W'(VERTS - 1));
    assign w_deq_accept = prim_dequeue && r_full[r_out_sel];

    // Completion and dequeue can coincide; they always touch different
    // slots (a slot being filled is never full, so it cannot be the one
    // being dequeued), so both updates are simply applied.
    always_comb begin
        w_full_next = r_full;
        if (w_last_cap) begin
            w_full_next[r_gather_sel] = 1'b1;
        end
        if (w_deq_accept) begin
            w_full_next[r_out_sel] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                for (int v = 0; v < VERTS; v++) begin
                    r_vert[s][v] <= '0;
                end
            end
            r_full        <= 2'b00;
            r_gather_sel  <= 1'b0;
            r_out_sel     <= 1'b0;
            r_issued      <= '0;
            r_captured    <= '0;
            r_cap_pending <= 1'b0;
            r_prim_count  <= 16'd0;
        end else begin
            // Data popped last cycle is on fifo_dout now; store it at the
            // next vertex position of the slot being filled.
            if (r_cap_pending) begin
                for (int v = 0; v < VERTS; v++) begin
                    if (r_captured == CNT_W'(v)) begin
                        r_vert[r_gather_sel][v] <= fifo_dout;
                    end
                end
            end

            r_cap_pending <= w_pop;

            if (w_last_cap) begin
                // issued == VERTS here, so no pop competes with the clear.
                r_gather_sel <= ~r_gather_sel;
                r_issued     <= '0;
                r_captured   <= '0;
            end else begin
                if (w_pop) begin
                    r_issued <= r_issued + 1'b1;
                end
                if (r_cap_pending) begin
                    r_captured <= r_captured + 1'b1;
                end
            end

            r_full <= w_full_next;

            if (w_deq_accept) begin
                r_out_sel    <= ~r_out_sel;
                r_prim_count <= r_prim_count + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Presentation: the slot selected by out_sel drives the outputs.
    // ------------------------------------------------------------------
    assign prim_valid = r_full[r_out_sel];
    assign prim_count = r_prim_count;

    generate
        for (genvar gi = 0; gi < VERTS; gi++) begin : g_out
            assign prim_data[gi*VERT_W +: VERT_W] =
                r_out_sel ? r_vert[1][gi] : r_vert[0][gi];
        end
    endgenerate

endmodule

// File: tb/tb_prim_assembler.sv
// ---------------------------------------------------------------------------
// tb_prim_assembler
//
// Directed bench for prim_assembler. Two instances: the default geometry
// (96-bit words, 2 channels, 3 vertices) and a swept one (32-bit words,
// 3 channels, 4 vertices). Each is fed by a small standard-mode FIFO model.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_prim_assembler;

    localparam int DW_A = 96;
    localparam int NC_A = 2;
    localparam int V_A  = 3;
    localparam int PW_A = V_A * NC_A * DW_A;   // 576
    localparam int DW_B = 32;
    localparam int NC_B = 3;
    localparam int V_B  = 4;
    localparam int PW_B = V_B * NC_B * DW_B;   // 384
    localparam int CW   = 576;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- instance A ----------------
    logic [NC_A-1:0]      empty_a;
    logic [NC_A*DW_A-1:0] dout_a = '0;
    logic [NC_A-1:0]      rd_en_a;
    logic [PW_A-1:0]      data_a;
    logic                 valid_a;
    logic                 deq_a = 1'b0;
    logic [15:0]          count_a;

    prim_assembler #(.DATA_W(DW_A), .NUM_CH(NC_A), .VERTS(V_A)) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (empty_a),
        .fifo_dout    (dout_a),
        .fifo_rd_en   (rd_en_a),
        .prim_data    (data_a),
        .prim_valid   (valid_a),
        .prim_dequeue (deq_a),
        .prim_count   (count_a)
    );

    // ---------------- instance B ----------------
    logic [NC_B-1:0]      empty_b;
    logic [NC_B*DW_B-1:0] dout_b = '0;
    logic [NC_B-1:0]      rd_en_b;
    logic [PW_B-1:0]      data_b;
    logic                 valid_b;
    logic                 deq_b = 1'b0;
    logic [15:0]          count_b;

    prim_assembler #(.DATA_W(DW_B), .NUM_CH(NC_B), .VERTS(V_B)) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (empty_b),
        .fifo_dout    (dout_b),
        .fifo_rd_en   (rd_en_b),
        .prim_data    (data_b),
        .prim_valid   (valid_b),
        .prim_dequeue (deq_b),
        .prim_count   (count_b)
    );

    // ---------------- FIFO models (standard read mode) ----------------
    logic [DW_A-1:0] mem_a [NC_A][64];
    int              wp_a  [NC_A] = '{0, 0};
    int              rp_a  [NC_A] = '{0, 0};
    logic [DW_B-1:0] mem_b [NC_B][16];
    int              wp_b  [NC_B] = '{0, 0, 0};
    int              rp_b  [NC_B] = '{0, 0, 0};

    always @(posedge clk) begin
        for (int c = 0; c < NC_A; c++) begin
            if (rd_en_a[c]) begin
                dout_a[c*DW_A +: DW_A] <= mem_a[c][rp_a[c]];
                rp_a[c] <= rp_a[c] + 1;
            end
        end
        for (int c = 0; c < NC_B; c++) begin
            if (rd_en_b[c]) begin
                dout_b[c*DW_B +: DW_B] <= mem_b[c][rp_b[c]];
                rp_b[c] <= rp_b[c] + 1;
            end
        end
    end

    always_comb begin
        empty_a = '0;
        empty_b = '0;
        for (int c = 0; c < NC_A; c++) empty_a[c] = (rp_a[c] == wp_a[c]);
        for (int c = 0; c < NC_B; c++) empty_b[c] = (rp_b[c] == wp_b[c]);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [CW-1:0] got,
                            input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s", tag);
        end
    endtask

    // ---------------- helpers ----------------
    function automatic logic [DW_A-1:0] va(input int ch, input int k);
        return {32'hA5A50000 + 32'(ch), 32'(k), 32'hC0DE0000 ^ 32'(k * 7 + ch)};
    endfunction

    function automatic logic [DW_B-1:0] vb(input int ch, input int k);
        return 32'hB0000000 + 32'(ch * 32'h1000) + 32'(k);
    endfunction

    // Expected primitive {C2,V2,C1,V1,C0,V0} from entries k0..k0+2.
    function automatic logic [PW_A-1:0] prim_a(input int k0);
        return {va(1, k0 + 2), va(0, k0 + 2), va(1, k0 + 1),
                va(0, k0 + 1), va(1, k0),     va(0, k0)};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_a(input int c, input int k);
        mem_a[c][wp_a[c]] = va(c, k);
        wp_a[c] = wp_a[c] + 1;
    endtask

    task automatic push_both_a(input int k0, input int n);
        for (int i = 0; i < n; i++) begin
            push_a(0, k0 + i);
            push_a(1, k0 + i);
        end
    endtask

    task automatic pulse_deq_a();
        deq_a = 1'b1;
        step();
        deq_a = 1'b0;
    endtask

    int pops;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW_B-1:0] exp_b;

        // ---------------- reset state ----------------
        #2;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_valid_a", CW'(valid_a), CW'(1'b0));
        check_eq("rst_data_a",  CW'(data_a),  CW'(0));
        check_eq("rst_rden_a",  CW'(rd_en_a), CW'(2'b00));
        check_eq("rst_count_a", CW'(count_a), CW'(16'd0));
        check_eq("rst_valid_b", CW'(valid_b), CW'(1'b0));
        rst = 1'b0;
        #1;
        check_eq("idle_rden_a", CW'(rd_en_a), CW'(2'b00));

        // ---------------- spurious dequeue ----------------
        pulse_deq_a();
        check_eq("spur_count", CW'(count_a), CW'(16'd0));
        check_eq("spur_valid", CW'(valid_a), CW'(1'b0));

        // ---------------- single primitive ----------------
        push_both_a(0, 3);
        #1;
        check_eq("sp_pop_c0", CW'(rd_en_a), CW'(2'b11));
        step();
        check_eq("sp_pop_c1", CW'(rd_en_a), CW'(2'b11));
        step();
        check_eq("sp_pop_c2", CW'(rd_en_a), CW'(2'b11));
        step();
        check_eq("sp_pop_c3", CW'(rd_en_a), CW'(2'b00));
        check_eq("sp_valid_c3", CW'(valid_a), CW'(1'b0));
        step();
        check_eq("sp_valid_c4", CW'(valid_a), CW'(1'b1));
        check_eq("sp_data_c4", CW'(data_a), CW'(prim_a(0)));
        step();
        check_eq("sp_hold_c5", CW'(data_a), CW'(prim_a(0)));
        pulse_deq_a();
        check_eq("sp_deq_valid", CW'(valid_a), CW'(1'b0));
        check_eq("sp_deq_count", CW'(count_a), CW'(16'd1));

        // ---------------- back-pressure ----------------
        push_both_a(3, 9);
        #1;
        pops = 0;
        repeat (20) begin
            if (rd_en_a == 2'b11) pops++;
            step();
        end
        check_eq("bp_pops", CW'(pops), CW'(6));
        check_eq("bp_rden_stall", CW'(rd_en_a), CW'(2'b00));
        check_eq("bp_data_held", CW'(data_a), CW'(prim_a(3)));
        pulse_deq_a();
        check_eq("bp_valid_next", CW'(valid_a), CW'(1'b1));
        check_eq("bp_data_next", CW'(data_a), CW'(prim_a(6)));
        check_eq("bp_count", CW'(count_a), CW'(16'd2));
        check_eq("bp_pop_resume", CW'(rd_en_a), CW'(2'b11));
        repeat (4) step();
        pulse_deq_a();
        check_eq("bp_data_third", CW'(data_a), CW'(prim_a(9)));
        check_eq("bp_count3", CW'(count_a), CW'(16'd3));
        pulse_deq_a();
        check_eq("bp_drained", CW'(valid_a), CW'(1'b0));
        check_eq("bp_count4", CW'(count_a), CW'(16'd4));

        // ---------------- starvation ----------------
        push_a(0, 12); push_a(0, 13); push_a(0, 14);
        push_a(1, 12);
        #1;
        pops = 0;
        repeat (6) begin
            if (rd_en_a == 2'b11) pops++;
            step();
        end
        check_eq("st_pops1", CW'(pops), CW'(1));
        check_eq("st_valid0", CW'(valid_a), CW'(1'b0));
        push_a(1, 13); push_a(1, 14);
        #1;
        pops = 0;
        repeat (6) begin
            if (rd_en_a == 2'b11) pops++;
            step();
        end
        check_eq("st_pops2", CW'(pops), CW'(2));
        check_eq("st_valid1", CW'(valid_a), CW'(1'b1));
        check_eq("st_data", CW'(data_a), CW'(prim_a(12)));
        pulse_deq_a();
        check_eq("st_count", CW'(count_a), CW'(16'd5));

        // ---------------- dequeue coincident with completion ----------------
        push_both_a(15, 6);
        #1;
        repeat (7) step();
        check_eq("sim_valid_c7", CW'(valid_a), CW'(1'b1));
        check_eq("sim_data_c7", CW'(data_a), CW'(prim_a(15)));
        pulse_deq_a();
        check_eq("sim_valid_c8", CW'(valid_a), CW'(1'b1));
        check_eq("sim_data_c8", CW'(data_a), CW'(prim_a(18)));
        check_eq("sim_count", CW'(count_a), CW'(16'd6));
        pulse_deq_a();
        check_eq("sim_drained", CW'(valid_a), CW'(1'b0));
        check_eq("sim_count2", CW'(count_a), CW'(16'd7));

        // ---------------- reset mid-gather ----------------
        push_both_a(21, 9);
        #1;
        repeat (6) step();
        check_eq("rm_valid_pre", CW'(valid_a), CW'(1'b1));
        check_eq("rm_rden_pre", CW'(rd_en_a), CW'(2'b11));
        #2;
        rst = 1'b1;
        #1;
        check_eq("rm_valid_rst", CW'(valid_a), CW'(1'b0));
        check_eq("rm_rden_rst", CW'(rd_en_a), CW'(2'b00));
        check_eq("rm_data_rst", CW'(data_a), CW'(0));
        check_eq("rm_count_rst", CW'(count_a), CW'(16'd0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rm_pop_after", CW'(rd_en_a), CW'(2'b11));
        repeat (4) step();
        check_eq("rm_valid_after", CW'(valid_a), CW'(1'b1));
        check_eq("rm_data_after", CW'(data_a), CW'(prim_a(26)));

        // ---------------- parameter sweep: 3 channels, 4 vertices ----------------
        for (int v = 0; v < V_B; v++) begin
            for (int c = 0; c < NC_B; c++) begin
                mem_b[c][wp_b[c]] = vb(c, v);
                wp_b[c] = wp_b[c] + 1;
            end
        end
        exp_b = '0;
        for (int v = 0; v < V_B; v++) begin
            for (int c = 0; c < NC_B; c++) begin
                exp_b[(v * NC_B + c) * DW_B +: DW_B] = vb(c, v);
            end
        end
        #1;
        check_eq("pb_pop_c0", CW'(rd_en_b), CW'(3'b111));
        for (int i = 1; i < V_B; i++) begin
            step();
            check_eq($sformatf("pb_pop_c%0d", i), CW'(rd_en_b), CW'(3'b111));
        end
        step();
        check_eq("pb_pop_c4", CW'(rd_en_b), CW'(3'b000));
        check_eq("pb_valid_c4", CW'(valid_b), CW'(1'b0));
        step();
        check_eq("pb_valid_c5", CW'(valid_b), CW'(1'b1));
        check_eq("pb_data_c5", CW'(data_b), CW'(exp_b));
        check_eq("pb_v3c2", CW'(data_b[(3 * NC_B + 2) * DW_B +: DW_B]), CW'(32'hB0002003));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
